// File: rtl/rot_pkg.sv
// rot_pkg: shared types and helpers for the iterated-rotation controller.
//   state_t            - controller FSM states (IDLE, BUSY, DONE)
//   left_to_right_amt  - converts a left-rotate amount into the equivalent
//                        right-rotate amount for a 2**n-bit word
package rot_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // (2**n - amt) mod 2**n; amt == 0 maps to 0.
    function automatic int unsigned left_to_right_amt(input int unsigned amt,
                                                      input int unsigned n);
        int unsigned mask;
        mask = (32'd1 << n) - 32'd1;
        return ((32'd1 << n) - amt) & mask;
    endfunction

endpackage

// File: rtl/param_right_shifter.sv
// param_right_shifter: combinational right-rotator for a 2**N-bit word.
// Ports:
//   data_i  - word to rotate (2**N bits)
//   amt_i   - right-rotate amount (N bits)
//   data_o  - data_i rotated right by amt_i
module param_right_shifter #(
    parameter int unsigned N = 3
) (
    input  logic [(1<<N)-1:0] data_i,
    input  logic [N-1:0]      amt_i,
    output logic [(1<<N)-1:0] data_o
);

    localparam int unsigned W = 1 << N;

    logic [2*W-1:0] dbl;

    // Shifting the doubled word right exposes the wrapped-around bits in the low half.
    always_comb begin
        dbl    = {data_i, data_i} >> amt_i;
        data_o = dbl[W-1:0];
    end

endmodule

// File: rtl/rotate_step_ctrl.sv
// rotate_step_ctrl: accepts a rotate command (word, amount, step count) over a
// valid/ready handshake, rotates the word right by the same amount once per
// clock for the requested number of steps, then presents the result on a
// valid/ready output.
// Optional feature macro: ROT_LEFT_EN (adds in_left; left rotation per step).
// Ports:
//   clk, reset_n            - clock (rising edge), async active-low reset
//   in_valid/in_ready       - command handshake
//   in_data, in_amt, in_steps - word, per-step amount, number of steps
//   in_left                 - (ROT_LEFT_EN only) rotate left instead of right
//   out_valid/out_ready     - result handshake
//   out_data                - rotated result (work register)
//   busy                    - command in flight (BUSY or DONE)
module rotate_step_ctrl
    import rot_pkg::*;
#(
    parameter int unsigned N      = 3,
    parameter int unsigned STEP_W = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [(1<<N)-1:0]   in_data,
    input  logic [N-1:0]        in_amt,
    input  logic [STEP_W-1:0]   in_steps,
`ifdef ROT_LEFT_EN
    input  logic                in_left,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [(1<<N)-1:0]   out_data,
    output logic                busy
);

    localparam int unsigned W = 1 << N;

    state_t              state_q, state_d;
    logic [W-1:0]        work_q, work_d;
    logic [N-1:0]        amt_q, amt_d;
    logic [STEP_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]        rot_out;
    logic [N-1:0]        amt_in_eff;

    param_right_shifter #(
        .N (N)
    ) u_rot (
        .data_i (work_q),
        .amt_i  (amt_q),
        .data_o (rot_out)
    );

`ifdef ROT_LEFT_EN
    // A left rotate by a is a right rotate by (2**N - a) mod 2**N.
    assign amt_in_eff = in_left ? N'(left_to_right_amt(32'(in_amt), N)) : in_amt;
`else
    assign amt_in_eff = in_amt;
`endif

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        amt_d   = amt_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    amt_d   = amt_in_eff;
                    cnt_d   = in_steps;
                    state_d = (in_steps == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                work_d = rot_out;
                cnt_d  = cnt_q - STEP_W'(1);
                if (cnt_q == STEP_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            amt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            amt_q   <= amt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = work_q;

endmodule

// File: tb/tb_rotate_step_ctrl.sv
module tb_rotate_step_ctrl;

    localparam int unsigned N      = 3;
    localparam int unsigned STEP_W = 4;
    localparam int unsigned W      = 1 << N;

    logic              clk;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_data;
    logic [N-1:0]      in_amt;
    logic [STEP_W-1:0] in_steps;
    logic              in_left;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic              busy;

    int n_checks;
    int n_fail;

    rotate_step_ctrl #(
        .N      (N),
        .STEP_W (STEP_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_steps  (in_steps),
`ifdef ROT_LEFT_EN
        .in_left   (in_left),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit-level reference: result bit i comes from source bit (i + k) mod W.
    function automatic logic [W-1:0] rotr_ref(input logic [W-1:0] d, input int k);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = d[(i + k) % W];
        return r;
    endfunction

    // Net right rotation after all steps; a left step of a equals a right step of W - a.
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input int amt,
                                           input int steps, input bit left);
        int total;
        total = (amt * steps) % W;
        if (left) total = (W - total) % W;
        return rotr_ref(d, total);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command from IDLE, check latency, result and busy, then complete
    // the result handshake after `hold` cycles of backpressure.
    task automatic run_cmd(input string tag, input logic [W-1:0] d, input int amt,
                           input int steps, input bit left, input int hold);
        logic [W-1:0] exp;
        logic [W-1:0] held;
        int           lat;
        exp = model(d, amt, steps, left);
        check_eq({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = N'(amt);
        in_steps = STEP_W'(steps);
        in_left  = left;
        tick();
        in_valid = 1'b0;
        in_data  = W'($urandom);
        // Edges after the accept edge until out_valid: one per step, none for S=0
        // (DONE is entered directly on the accept edge).
        lat = 0;
        while (!out_valid && lat < 40) begin
            check_eq({tag, ".busy_run"}, 32'(busy), 32'd1);
            tick();
            lat++;
        end
        check_eq({tag, ".latency"}, 32'(lat), 32'(steps));
        check_eq({tag, ".data"}, 32'(out_data), 32'(exp));
        check_eq({tag, ".busy_done"}, 32'(busy), 32'd1);
        held = out_data;
        // Backpressure: offer a competing command that must be ignored.
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            in_steps = STEP_W'($urandom);
            tick();
            check_eq({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check_eq({tag, ".hold_data"}, 32'(out_data), 32'(held));
            check_eq({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, ".post_ready"}, 32'(in_ready), 32'd1);
        check_eq({tag, ".post_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, ".post_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_steps  = '0;
        in_left   = 1'b0;
        out_ready = 1'b0;
        #12;
        check_eq("rst.in_ready", 32'(in_ready), 32'd1);
        check_eq("rst.out_valid", 32'(out_valid), 32'd0);
        check_eq("rst.out_data", 32'(out_data), 32'd0);
        check_eq("rst.busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        tick();

        run_cmd("t1", 8'h96, 1, 1, 1'b0, 0);
        check_eq("t1.const", 32'(model(8'h96, 1, 1, 1'b0)), 32'h4B);
        run_cmd("t2", 8'h96, 3, 3, 1'b0, 0);
        run_cmd("t3", 8'hA5, 5, 0, 1'b0, 0);
        run_cmd("t4", 8'h3C, 2, 4, 1'b0, 5);
        run_cmd("amt0", 8'h5E, 0, 7, 1'b0, 1);
        run_cmd("smax", 8'h81, 3, 15, 1'b0, 0);

        // Reset while BUSY: outputs return to reset values without a clock edge.
        in_valid = 1'b1;
        in_data  = 8'hC3;
        in_amt   = 3'd1;
        in_steps = 4'd15;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check_eq("t5.busy_pre", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t5.out_valid", 32'(out_valid), 32'd0);
        check_eq("t5.out_data", 32'(out_data), 32'd0);
        check_eq("t5.busy", 32'(busy), 32'd0);
        check_eq("t5.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check_eq("t5.no_replay", 32'(out_valid), 32'd0);
        run_cmd("t5.next", 8'h96, 3, 3, 1'b0, 0);

`ifdef ROT_LEFT_EN
        run_cmd("t6.left", 8'h96, 1, 2, 1'b1, 0);
        check_eq("t6.left_const", 32'(model(8'h96, 1, 2, 1'b1)), 32'h5A);
        run_cmd("t6.right", 8'h96, 1, 2, 1'b0, 0);
        run_cmd("t6.left0", 8'h69, 0, 3, 1'b1, 0);
`endif

        for (int k = 0; k < 30; k++) begin
            bit lft;
            lft = 1'b0;
`ifdef ROT_LEFT_EN
            lft = 1'($urandom);
`endif
            run_cmd("rnd", W'($urandom), int'($urandom_range(0, W - 1)),
                    int'($urandom_range(0, 15)), lft, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
